// File: rtl/fb_scanout.sv
// VGA raster timing and framebuffer scan-out: sweeps the raster, fetches one pixel
// per active position and drives sync/enable/colour two pixel ticks behind the counters.
module fb_scanout #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pix_en,
   output logic [18:0] rd_addr,
   output logic        rd_en,
   input  logic [5:0]  rd_data,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic [5:0]  rgb,
   output logic        vblank,
   output logic        frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

   // Framebuffer line stride is fixed by the rasterizer's layout, not by H_ACTIVE.
   localparam logic [18:0] STRIDE = 19'd640;

   logic [HW-1:0] hcnt;
   logic [VW-1:0] vcnt;
   logic          h_wrap;
   logic          v_wrap;
   logic          active;
   logic          de_a;
   logic          hs_a;
   logic          vs_a;
   logic          vb_a;

   assign h_wrap = (hcnt == H_LAST);
   assign v_wrap = (vcnt == V_LAST);
   assign active = (hcnt < H_ACT) && (vcnt < V_ACT);

   always_ff @(posedge clk) begin
      if (reset) begin
         hcnt        <= '0;
         vcnt        <= '0;
         rd_addr     <= '0;
         rd_en       <= 1'b0;
         de_a        <= 1'b0;
         hs_a        <= 1'b0;
         vs_a        <= 1'b0;
         vb_a        <= 1'b0;
         de          <= 1'b0;
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         vblank      <= 1'b0;
         rgb         <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         if (pix_en) begin
            hcnt <= h_wrap ? '0 : hcnt + 1'b1;
            if (h_wrap) begin
               vcnt <= v_wrap ? '0 : vcnt + 1'b1;
            end
            frame_start <= h_wrap && v_wrap;

            // Stage A: fetch and timing flags from the current raster position.
            rd_en <= active;
            if (active) begin
               rd_addr <= STRIDE * 19'(vcnt) + 19'(hcnt);
            end
            de_a <= active;
            hs_a <= (hcnt >= HS_BEG) && (hcnt <= HS_END);
            vs_a <= (vcnt >= VS_BEG) && (vcnt <= VS_END);
            vb_a <= (vcnt >= V_ACT);

            // Stage B: rd_data now answers the stage-A address, so pins stay aligned.
            de     <= de_a;
            hsync  <= hs_a ? SYNC_POL : ~SYNC_POL;
            vsync  <= vs_a ? SYNC_POL : ~SYNC_POL;
            vblank <= vb_a;
            rgb    <= de_a ? rd_data : 6'b0;
         end
      end
   end

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout on a shrunken raster (30x15 total, 16x8 active)
// so whole frames fit in a short run; pix_en is issued one clk in four.
module tb_fb_scanout;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pix_en = 1'b0;
   logic [18:0] rd_addr;
   logic        rd_en;
   logic [5:0]  rd_data = 6'h00;
   logic        hsync;
   logic        vsync;
   logic        de;
   logic [5:0]  rgb;
   logic        vblank;
   logic        frame_start;

   logic        ram_force = 1'b0;

   int n_assert = 0;
   int n_fail   = 0;
   int tick_n   = 0;

   int fs_cnt   = 0;
   int fs_wide  = 0;
   int fs_tick[$];
   logic fs_prev = 1'b0;

   int hs_low_l1   = 0;
   int hs_first_l1 = -1;
   int vs_low_cnt  = 0;
   int vs_min      = 99;
   int vs_max      = -1;
   int de_cnt      = 0;
   int vb_cnt      = 0;

   fb_scanout #(
      .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
      .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
      .SYNC_POL(1'b0)
   ) dut (
      .clk(clk),
      .reset(reset),
      .pix_en(pix_en),
      .rd_addr(rd_addr),
      .rd_en(rd_en),
      .rd_data(rd_data),
      .hsync(hsync),
      .vsync(vsync),
      .de(de),
      .rgb(rgb),
      .vblank(vblank),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   // 1-clk synchronous framebuffer returning the low address bits
   always @(posedge clk) rd_data <= ram_force ? 6'h3F : rd_addr[5:0];

   always @(negedge clk) begin
      if (frame_start) begin
         fs_cnt++;
         fs_tick.push_back(tick_n);
         if (fs_prev) fs_wide++;
      end
      fs_prev = frame_start;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One pixel tick, then frame-0 statistics; pins show raster position tick_n-2.
   task automatic pix_tick();
      int p, ph, pv;
      @(negedge clk);
      pix_en = 1'b1;
      tick_n++;
      @(negedge clk);
      pix_en = 1'b0;
      repeat (2) @(negedge clk);
      if (tick_n >= 2 && tick_n <= 451) begin
         p  = tick_n - 2;
         ph = p % 30;
         pv = p / 30;
         if (pv == 1 && hsync == 1'b0) begin
            hs_low_l1++;
            if (hs_first_l1 < 0) hs_first_l1 = ph;
         end
         if (vsync == 1'b0) begin
            vs_low_cnt++;
            if (pv < vs_min) vs_min = pv;
            if (pv > vs_max) vs_max = pv;
         end
         if (de) de_cnt++;
         if (vblank) vb_cnt++;
      end
   endtask

   task automatic run_to(input int target);
      while (tick_n < target) pix_tick();
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("in_reset_de", int'(de), 0);
      chk("in_reset_hsync", int'(hsync), 1);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      chk("idle_rd_addr", int'(rd_addr), 0);
      chk("idle_rd_en", int'(rd_en), 0);
      chk("idle_de", int'(de), 0);
      chk("idle_rgb", int'(rgb), 0);
      chk("idle_vblank", int'(vblank), 0);
      chk("idle_hsync", int'(hsync), 1);
      chk("idle_vsync", int'(vsync), 1);
      chk("idle_frame_start_seen", fs_cnt, 0);

      pix_tick();
      chk("t1_rd_en", int'(rd_en), 1);
      chk("t1_rd_addr", int'(rd_addr), 0);
      chk("t1_de", int'(de), 0);
      pix_tick();
      chk("t2_de", int'(de), 1);
      chk("t2_rgb", int'(rgb), 0);
      chk("t2_rd_addr", int'(rd_addr), 1);
      pix_tick();
      chk("t3_rd_addr", int'(rd_addr), 2);
      pix_tick();
      chk("t4_rgb", int'(rgb), 2);
      chk("t4_vblank", int'(vblank), 0);

      run_to(36);
      chk("l1p5_rd_addr", int'(rd_addr), 645);
      pix_tick();
      chk("l1p5_rgb", int'(rgb), 5);
      chk("l1p6_rd_addr", int'(rd_addr), 646);

      repeat (10) @(negedge clk);
      chk("hold_rd_addr", int'(rd_addr), 646);
      chk("hold_rgb", int'(rgb), 5);
      chk("hold_de", int'(de), 1);
      chk("hold_hsync", int'(hsync), 1);
      chk("hold_vsync", int'(vsync), 1);
      chk("hold_frame_start_seen", fs_cnt, 0);

      // Back porch in both directions (h=27, v=13) with the RAM driving all ones
      run_to(416);
      ram_force = 1'b1;
      run_to(418);
      chk("blank_rd_en", int'(rd_en), 0);
      chk("blank_rd_addr_hold", int'(rd_addr), 4495);
      pix_tick();
      chk("blank_de", int'(de), 0);
      chk("blank_rgb", int'(rgb), 0);
      chk("blank_vblank", int'(vblank), 1);
      chk("blank_hsync", int'(hsync), 1);
      chk("blank_vsync", int'(vsync), 1);
      ram_force = 1'b0;

      run_to(905);
      chk("hs_low_ticks_line1", hs_low_l1, 6);
      chk("hs_first_pixel", hs_first_l1, 20);
      chk("vs_low_ticks", vs_low_cnt, 60);
      chk("vs_first_line", vs_min, 10);
      chk("vs_last_line", vs_max, 11);
      chk("de_ticks_frame", de_cnt, 128);
      chk("vblank_ticks_frame", vb_cnt, 210);
      chk("fs_pulses", fs_cnt, 2);
      chk("fs_wide", fs_wide, 0);
      if (fs_tick.size() >= 2) begin
         chk("fs_first_tick", fs_tick[0], 450);
         chk("fs_spacing", fs_tick[1] - fs_tick[0], 450);
      end else begin
         chk("fs_tick_count", fs_tick.size(), 2);
      end

      // Reset at h=10, v=5 coinciding with a pix_en
      run_to(1060);
      @(negedge clk);
      reset  = 1'b1;
      pix_en = 1'b1;
      @(negedge clk);
      reset  = 1'b0;
      pix_en = 1'b0;
      chk("rst_rd_addr", int'(rd_addr), 0);
      chk("rst_rd_en", int'(rd_en), 0);
      chk("rst_de", int'(de), 0);
      chk("rst_rgb", int'(rgb), 0);
      chk("rst_hsync", int'(hsync), 1);
      chk("rst_vsync", int'(vsync), 1);
      chk("rst_vblank", int'(vblank), 0);
      pix_tick();
      chk("rst_t1_rd_addr", int'(rd_addr), 0);
      chk("rst_t1_rd_en", int'(rd_en), 1);
      chk("rst_t1_de", int'(de), 0);
      pix_tick();
      chk("rst_t2_rd_addr", int'(rd_addr), 1);
      chk("rst_t2_de", int'(de), 1);
      chk("rst_t2_rgb", int'(rgb), 0);
      pix_tick();
      chk("rst_t3_rd_addr", int'(rd_addr), 2);
      chk("rst_t3_rgb", int'(rgb), 1);
      chk("rst_no_fs", fs_cnt, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
